// File: rtl/udma_i2c_xfer_sched.sv
// Job sequencer that drives the I2C uDMA cfg register bus: programs the RX/TX channels, polls for
// completion, collects the sticky NACK, and on timeout/abort resets and disables both channels.
module udma_i2c_xfer_sched #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int TIMEOUT_W      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      job_valid_i,
  output logic                      job_ready_o,
  input  logic [L2_AWIDTH_NOAL-1:0] job_rx_addr_i,
  input  logic [TRANS_SIZE-1:0]     job_rx_size_i,
  input  logic [L2_AWIDTH_NOAL-1:0] job_tx_addr_i,
  input  logic [TRANS_SIZE-1:0]     job_tx_size_i,
  input  logic [TIMEOUT_W-1:0]      timeout_i,
  input  logic                      abort_i,
  output logic                      cfg_valid_o,
  output logic                      cfg_rwn_o,
  output logic [4:0]                cfg_addr_o,
  output logic [31:0]               cfg_data_o,
  input  logic [31:0]               cfg_data_i,
  input  logic                      cfg_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      nack_o,
  output logic                      timeout_o,
  output logic                      err_o
);

  // Encoding order matters: each straight-line step advances to the next enum value.
  typedef enum logic [3:0] {
    S_IDLE, S_RXA, S_RXS, S_RXC, S_TXA, S_TXS, S_TXC, S_SETTLE,
    S_PTX, S_PRX, S_RDACK, S_RST1, S_RST0, S_RCLR_TX, S_RCLR_RX, S_DONE
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        rwn;
    logic [4:0]  addr;
    logic [31:0] data;
  } acc_t;

  state_e                    state_r;
  acc_t                      acc_r;
  logic                      ready_r, busy_r, done_r, nack_r, tmo_r, err_r, pend_r;
  logic [L2_AWIDTH_NOAL-1:0] rx_addr_r, tx_addr_r;
  logic [TRANS_SIZE-1:0]     rx_size_r, tx_size_r;
  logic [TIMEOUT_W-1:0]      tmo_lim_r, cnt_r;

  // Cfg access issued on entry to each state; states without bus traffic get an idle bus.
  function automatic acc_t acc_f(input state_e s,
                                 input logic [L2_AWIDTH_NOAL-1:0] rxa,
                                 input logic [TRANS_SIZE-1:0]     rxs,
                                 input logic [L2_AWIDTH_NOAL-1:0] txa,
                                 input logic [TRANS_SIZE-1:0]     txs);
    acc_t a;
    a = '0;
    a.valid = 1'b1;
    case (s)
      S_RXA:     begin a.addr = 5'd0;  a.data = 32'(rxa);      end
      S_RXS:     begin a.addr = 5'd1;  a.data = 32'(rxs);      end
      S_RXC:     begin a.addr = 5'd2;  a.data = 32'h0000_0010; end
      S_TXA:     begin a.addr = 5'd4;  a.data = 32'(txa);      end
      S_TXS:     begin a.addr = 5'd5;  a.data = 32'(txs);      end
      S_TXC:     begin a.addr = 5'd6;  a.data = 32'h0000_0010; end
      S_PTX:     begin a.addr = 5'd6;  a.rwn  = 1'b1;          end
      S_PRX:     begin a.addr = 5'd2;  a.rwn  = 1'b1;          end
      S_RDACK:   begin a.addr = 5'd10; a.rwn  = 1'b1;          end
      S_RST1:    begin a.addr = 5'd9;  a.data = 32'h0000_0001; end
      S_RST0:    begin a.addr = 5'd9;  a.data = 32'h0000_0000; end
      S_RCLR_TX: begin a.addr = 5'd6;  a.data = 32'h0000_0020; end
      S_RCLR_RX: begin a.addr = 5'd2;  a.data = 32'h0000_0020; end
      default:   a = '0;
    endcase
    return a;
  endfunction

  function automatic acc_t acc_of(input state_e s);
    return acc_f(s, rx_addr_r, rx_size_r, tx_addr_r, tx_size_r);
  endfunction

  logic   retire_s, poll_st_s, tmo_hit_s, abort_hit_s, stop_s, chan_busy_s, unused_s;
  state_e adv_s;

  assign retire_s    = acc_r.valid & cfg_ready_i;
  assign poll_st_s   = (state_r == S_SETTLE) || (state_r == S_PTX) || (state_r == S_PRX);
  assign tmo_hit_s   = poll_st_s && (tmo_lim_r != '0) && (cnt_r == tmo_lim_r);
  assign abort_hit_s = abort_i && (state_r inside {S_RXA, S_RXS, S_RXC, S_TXA, S_TXS, S_TXC,
                                                   S_SETTLE, S_PTX, S_PRX, S_RDACK});
  assign stop_s      = pend_r | tmo_hit_s | abort_hit_s;
  assign chan_busy_s = (cfg_data_i[5:4] != 2'b00);
  assign adv_s       = state_e'(state_r + 4'd1);
  assign unused_s    = ^{cfg_data_i[31:6], cfg_data_i[3:1]};

  // Job sequencing FSM with registered bus and status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= S_IDLE;
      acc_r     <= '0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      nack_r    <= 1'b0;
      tmo_r     <= 1'b0;
      err_r     <= 1'b0;
      pend_r    <= 1'b0;
      rx_addr_r <= '0;
      tx_addr_r <= '0;
      rx_size_r <= '0;
      tx_size_r <= '0;
      tmo_lim_r <= '0;
      cnt_r     <= '0;
    end else begin
      if (tmo_hit_s) begin
        tmo_r  <= 1'b1;
        pend_r <= 1'b1;
      end
      if (abort_hit_s) begin
        err_r  <= 1'b1;
        pend_r <= 1'b1;
      end
      if (poll_st_s && (cnt_r != {TIMEOUT_W{1'b1}})) cnt_r <= cnt_r + TIMEOUT_W'(1);
      case (state_r)
        S_IDLE: begin
          if (job_valid_i) begin
            rx_addr_r <= job_rx_addr_i;
            rx_size_r <= job_rx_size_i;
            tx_addr_r <= job_tx_addr_i;
            tx_size_r <= job_tx_size_i;
            tmo_lim_r <= timeout_i;
            nack_r    <= 1'b0;
            tmo_r     <= 1'b0;
            err_r     <= ~|job_tx_size_i;
            pend_r    <= 1'b0;
            cnt_r     <= '0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b1;
            if (job_tx_size_i == '0) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end else if (job_rx_size_i == '0) begin
              state_r <= S_TXA;
              acc_r   <= acc_f(S_TXA, job_rx_addr_i, job_rx_size_i, job_tx_addr_i, job_tx_size_i);
            end else begin
              state_r <= S_RXA;
              acc_r   <= acc_f(S_RXA, job_rx_addr_i, job_rx_size_i, job_tx_addr_i, job_tx_size_i);
            end
          end
        end
        S_RXA, S_RXS, S_RXC, S_TXA, S_TXS: begin
          if (retire_s) begin
            state_r <= stop_s ? S_RST1 : adv_s;
            acc_r   <= acc_of(stop_s ? S_RST1 : adv_s);
          end
        end
        S_TXC: begin
          if (retire_s) begin
            state_r <= stop_s ? S_RST1 : S_SETTLE;
            acc_r   <= acc_of(stop_s ? S_RST1 : S_SETTLE);
            cnt_r   <= '0;
          end
        end
        S_SETTLE: begin
          if (stop_s) begin
            state_r <= S_RST1;
            acc_r   <= acc_of(S_RST1);
          end else if (cnt_r == TIMEOUT_W'(1)) begin
            state_r <= S_PTX;
            acc_r   <= acc_of(S_PTX);
          end
        end
        // A busy channel leaves the read request asserted, which reissues the poll.
        S_PTX, S_PRX: begin
          if (retire_s) begin
            if (stop_s) begin
              state_r <= S_RST1;
              acc_r   <= acc_of(S_RST1);
            end else if (!chan_busy_s) begin
              state_r <= ((state_r == S_PRX) || (rx_size_r == '0)) ? S_RDACK : S_PRX;
              acc_r   <= acc_of(((state_r == S_PRX) || (rx_size_r == '0)) ? S_RDACK : S_PRX);
            end
          end
        end
        S_RDACK: begin
          if (retire_s) begin
            nack_r  <= cfg_data_i[0];
            state_r <= stop_s ? S_RST1 : S_DONE;
            acc_r   <= acc_of(stop_s ? S_RST1 : S_DONE);
            done_r  <= ~stop_s;
          end
        end
        S_RST1, S_RST0, S_RCLR_TX, S_RCLR_RX: begin
          if (retire_s) begin
            state_r <= adv_s;
            acc_r   <= acc_of(adv_s);
            done_r  <= (state_r == S_RCLR_RX);
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          acc_r   <= '0;
        end
      endcase
    end
  end

  assign job_ready_o = ready_r;
  assign cfg_valid_o = acc_r.valid;
  assign cfg_rwn_o   = acc_r.rwn;
  assign cfg_addr_o  = acc_r.addr;
  assign cfg_data_o  = acc_r.data;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign nack_o      = nack_r;
  assign timeout_o   = tmo_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_udma_i2c_xfer_sched.sv
// Directed bench: behavioural cfg slave with scripted status replies, access log and stall injection.
module tb_udma_i2c_xfer_sched;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        job_valid_i, job_ready_o, abort_i;
  logic [11:0] job_rx_addr_i, job_tx_addr_i;
  logic [15:0] job_rx_size_i, job_tx_size_i, timeout_i;
  logic        cfg_valid_o, cfg_rwn_o, cfg_ready_i;
  logic [4:0]  cfg_addr_o;
  logic [31:0] cfg_data_o, cfg_data_i;
  logic        busy_o, done_o, nack_o, timeout_o, err_o;

  udma_i2c_xfer_sched dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_rx_addr_i(job_rx_addr_i), .job_rx_size_i(job_rx_size_i),
    .job_tx_addr_i(job_tx_addr_i), .job_tx_size_i(job_tx_size_i),
    .timeout_i(timeout_i), .abort_i(abort_i),
    .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o), .cfg_addr_o(cfg_addr_o),
    .cfg_data_o(cfg_data_o), .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i),
    .busy_o(busy_o), .done_o(done_o), .nack_o(nack_o), .timeout_o(timeout_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave model state
  logic [37:0] log_q[$];
  int          tx_rd = 0;
  int          tx_mode = 0;     // 0: 0x30,0x30,0x00  1: always 0x00  2: always 0x10
  logic [31:0] ack_val = 32'h0;
  int          done_cnt = 0;
  logic [2:0]  done_flags = 3'b000;
  int          stall_left = 0, stall_seen = 0, stall_bad = 0;
  logic [4:0]  stall_addr = 5'd0;
  logic [31:0] stall_data = 32'h0;

  // Retired accesses are logged and answered half a cycle before the edge that consumes them.
  always @(negedge clk_i) begin
    if (cfg_valid_o && cfg_ready_i) begin
      log_q.push_back({cfg_rwn_o, cfg_addr_o, cfg_rwn_o ? 32'h0 : cfg_data_o});
      case (cfg_addr_o)
        5'd6: begin
          if (tx_mode == 0)      cfg_data_i = (tx_rd < 2) ? 32'h30 : 32'h0;
          else if (tx_mode == 1) cfg_data_i = 32'h0;
          else                   cfg_data_i = 32'h10;
          if (cfg_rwn_o) tx_rd++;
        end
        5'd10:   cfg_data_i = ack_val;
        default: cfg_data_i = 32'h0;
      endcase
    end else begin
      cfg_data_i = 32'h0;
    end
    if (done_o) begin
      done_cnt++;
      done_flags = {nack_o, timeout_o, err_o};
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (stall_left > 0 && cfg_valid_o && !cfg_rwn_o && cfg_addr_o == stall_addr) begin
      cfg_ready_i = 1'b0;
      stall_left--;
      stall_seen++;
      if (cfg_data_o !== stall_data) stall_bad++;
    end else begin
      cfg_ready_i = 1'b1;
    end
  end

  task automatic start_job(input logic [11:0] rxa, input logic [15:0] rxs,
                           input logic [11:0] txa, input logic [15:0] txs, input logic [15:0] tmo);
    @(posedge clk_i);
    #2;
    log_q.delete();
    tx_rd = 0;
    done_cnt = 0;
    done_flags = 3'b000;
    @(negedge clk_i);
    job_rx_addr_i = rxa; job_rx_size_i = rxs;
    job_tx_addr_i = txa; job_tx_size_i = txs;
    timeout_i = tmo;
    job_valid_i = 1'b1;
    @(negedge clk_i);
    job_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check_eq({tag, "_done_seen"}, 64'(n < 500), 64'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic check_log(input string tag, input int idx, input logic rwn,
                           input logic [4:0] addr, input logic [31:0] data);
    logic [37:0] obs;
    obs = (idx < log_q.size()) ? log_q[idx] : {38{1'b1}};
    check_eq($sformatf("%s_acc%0d", tag, idx), 64'(obs), 64'({rwn, addr, data}));
  endtask

  int n_r6, n_w5;

  initial begin
    rst_i = 1'b1; job_valid_i = 1'b0; abort_i = 1'b0; cfg_ready_i = 1'b1; cfg_data_i = 32'h0;
    job_rx_addr_i = 12'h0; job_rx_size_i = 16'h0; job_tx_addr_i = 12'h0; job_tx_size_i = 16'h0;
    timeout_i = 16'h0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_ready", 64'(job_ready_o), 64'd1);
    check_eq("rst_bus", 64'({cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o}), 64'd0);
    check_eq("rst_status", 64'({busy_o, done_o, nack_o, timeout_o, err_o}), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Full RX+TX job with two busy TX polls
    tx_mode = 0; ack_val = 32'h0;
    start_job(12'h100, 16'd8, 12'h200, 16'd4, 16'd0);
    check_eq("t1_busy", 64'({busy_o, job_ready_o}), 64'b10);
    wait_done("t1");
    check_eq("t1_nacc", 64'(log_q.size()), 64'd11);
    check_log("t1", 0, 1'b0, 5'd0, 32'h100);
    check_log("t1", 1, 1'b0, 5'd1, 32'd8);
    check_log("t1", 2, 1'b0, 5'd2, 32'h10);
    check_log("t1", 3, 1'b0, 5'd4, 32'h200);
    check_log("t1", 4, 1'b0, 5'd5, 32'd4);
    check_log("t1", 5, 1'b0, 5'd6, 32'h10);
    check_log("t1", 6, 1'b1, 5'd6, 32'h0);
    check_log("t1", 7, 1'b1, 5'd6, 32'h0);
    check_log("t1", 8, 1'b1, 5'd6, 32'h0);
    check_log("t1", 9, 1'b1, 5'd2, 32'h0);
    check_log("t1", 10, 1'b1, 5'd10, 32'h0);
    check_eq("t1_flags", 64'(done_flags), 64'b000);
    check_eq("t1_idle", 64'({busy_o, job_ready_o}), 64'b01);

    // TX-only job with NACK
    tx_mode = 1; ack_val = 32'h1;
    start_job(12'h0, 16'd0, 12'h3A, 16'd3, 16'd0);
    wait_done("t2");
    check_eq("t2_nacc", 64'(log_q.size()), 64'd5);
    check_log("t2", 0, 1'b0, 5'd4, 32'h3A);
    check_log("t2", 1, 1'b0, 5'd5, 32'd3);
    check_log("t2", 2, 1'b0, 5'd6, 32'h10);
    check_log("t2", 3, 1'b1, 5'd6, 32'h0);
    check_log("t2", 4, 1'b1, 5'd10, 32'h0);
    check_eq("t2_flags", 64'(done_flags), 64'b100);
    check_eq("t2_nack_held", 64'(nack_o), 64'd1);

    // Slave stalls TX_SIZE write for 5 cycles
    tx_mode = 1; ack_val = 32'h0;
    stall_addr = 5'd5; stall_data = 32'd6; stall_seen = 0; stall_bad = 0; stall_left = 5;
    start_job(12'h7, 16'd1, 12'h33, 16'd6, 16'd0);
    wait_done("t3");
    check_eq("t3_stall_cycles", 64'(stall_seen), 64'd5);
    check_eq("t3_stall_unstable", 64'(stall_bad), 64'd0);
    n_w5 = 0;
    foreach (log_q[i]) if (log_q[i][37:32] == 6'b0_00101) n_w5++;
    check_eq("t3_size_retires", 64'(n_w5), 64'd1);
    check_eq("t3_nacc", 64'(log_q.size()), 64'd9);
    check_eq("t3_flags", 64'(done_flags), 64'b000);

    // Poll timeout with TX channel never finishing
    tx_mode = 2;
    start_job(12'h0, 16'd0, 12'h10, 16'd2, 16'd20);
    wait_done("t4");
    n_r6 = 0;
    foreach (log_q[i]) if (log_q[i][37:32] == 6'b1_00110) n_r6++;
    check_eq("t4_polls", 64'(n_r6), 64'd19);
    check_eq("t4_nacc", 64'(log_q.size()), 64'd26);
    check_log("t4", 2, 1'b0, 5'd6, 32'h10);
    check_log("t4", 22, 1'b0, 5'd9, 32'h1);
    check_log("t4", 23, 1'b0, 5'd9, 32'h0);
    check_log("t4", 24, 1'b0, 5'd6, 32'h20);
    check_log("t4", 25, 1'b0, 5'd2, 32'h20);
    check_eq("t4_flags", 64'(done_flags), 64'b010);

    // Abort while RX_SIZE write is stalled
    tx_mode = 1;
    stall_addr = 5'd1; stall_data = 32'd2; stall_seen = 0; stall_bad = 0; stall_left = 5;
    start_job(12'h40, 16'd2, 12'h80, 16'd1, 16'd0);
    for (int k = 0; k < 50 && stall_seen < 2; k++) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    wait_done("t5");
    check_eq("t5_nacc", 64'(log_q.size()), 64'd6);
    check_log("t5", 0, 1'b0, 5'd0, 32'h40);
    check_log("t5", 1, 1'b0, 5'd1, 32'd2);
    check_log("t5", 2, 1'b0, 5'd9, 32'h1);
    check_log("t5", 3, 1'b0, 5'd9, 32'h0);
    check_log("t5", 4, 1'b0, 5'd6, 32'h20);
    check_log("t5", 5, 1'b0, 5'd2, 32'h20);
    check_eq("t5_flags", 64'(done_flags), 64'b001);

    // Reset while polling TX
    tx_mode = 2;
    start_job(12'h0, 16'd0, 12'h11, 16'd1, 16'd0);
    begin
      int k = 0;
      while (tx_rd < 2 && k < 200) begin
        @(negedge clk_i);
        k++;
      end
      check_eq("t6_polling", 64'(k < 200), 64'd1);
    end
    rst_i = 1'b1;
    #1;
    check_eq("t6_rst_state", 64'({busy_o, job_ready_o, cfg_valid_o, err_o}), 64'b0100);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("t6_after", 64'({busy_o, job_ready_o, done_cnt != 0}), 64'b010);

    // Zero TX size: immediate error completion
    start_job(12'h5, 16'd4, 12'h6, 16'd0, 16'd0);
    check_eq("t7_done_now", 64'({done_o, err_o, cfg_valid_o}), 64'b110);
    @(negedge clk_i);
    check_eq("t7_back_idle", 64'({done_o, job_ready_o, busy_o}), 64'b010);
    check_eq("t7_nacc", 64'(log_q.size()), 64'd0);
    check_eq("t7_err_held", 64'(err_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
